pong_game_ctrl: RTL

- Game-level controller that sits directly downstream of pong_graph's hit/miss outputs and upstream of its gra_still input.
- Runs the new-game / play / new-ball / game-over FSM and keeps both players' BCD scores and the current rally length.
- Drives gra_still to freeze and recentre the ball, and exposes state, scores and winner to the text/score overlay.

---
 rtl/pong_pkg.sv | 31 +++
 rtl/pong_game_ctrl_if.sv | 28 ++
 rtl/bcd2_counter.sv | 26 ++
 rtl/pong_game_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared game state codes, winner codes, frame tick position and BCD helper
// No ports. Imported by the game controller, its BCD counter and the graphics refresh tick.
package pong_pkg;

  // game_state encoding seen by the text/score overlay
  localparam logic [1:0] ST_NEWGAME = 2'b00;
  localparam logic [1:0] ST_PLAY    = 2'b01;
  localparam logic [1:0] ST_NEWBALL = 2'b10;
  localparam logic [1:0] ST_OVER    = 2'b11;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  // frame tick position, just below the visible area
  localparam logic [9:0] TICK_X_DEF = 10'd0;
  localparam logic [9:0] TICK_Y_DEF = 10'd481;

  // two-digit BCD increment, holds at 99
  function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99)
      r = v;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// rtl/pong_game_ctrl_if.sv - signal bundle between VGA/graphics/buttons and the game controller
// Inputs to controller: x, y (scan position), btn (pads), hit, miss (from pong_graph).
// Outputs of controller: gra_still, game_state, score_l, score_r, rally, winner.
interface pong_game_ctrl_if;
  logic [9:0] x;
  logic [9:0] y;
  logic [3:0] btn;
  logic [1:0] hit;
  logic [1:0] miss;
  logic       gra_still;
  logic [1:0] game_state;
  logic [7:0] score_l;
  logic [7:0] score_r;
  logic [7:0] rally;
  logic [1:0] winner;

  // environment side: drives scan position, buttons and ball events
  modport master (
    output x, y, btn, hit, miss,
    input  gra_still, game_state, score_l, score_r, rally, winner
  );

  // controller side
  modport slave (
    input  x, y, btn, hit, miss,
    output gra_still, game_state, score_l, score_r, rally, winner
  );
endinterface

// File: rtl/bcd2_counter.sv
// rtl/bcd2_counter.sv - two-digit BCD counter with clear, increment and saturation at 99
// Ports: clk, reset (async, active-high), i_clr (priority clear), i_inc, o_count (BCD).
module bcd2_counter
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clr,
  input  logic       i_inc,
  output logic [7:0] o_count
);

  logic [7:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_count <= 8'h00;
    else if (i_clr)
      r_count <= 8'h00;
    else if (i_inc)
      r_count <= bcd2_inc(r_count);
  end

  assign o_count = r_count;

endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong game controller: new-game/play/new-ball/over FSM, scores, rally
// Ports: clk, reset (async, active-high), bus (slave side of pong_game_ctrl_if):
//   x/y scan position, btn pads, hit/miss ball events in; gra_still, game_state,
//   score_l, score_r, rally, winner out (all registered).
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter logic [7:0] WIN_SCORE_BCD = 8'h11,
  parameter int         WAIT_FRAMES   = 120,
  parameter logic [9:0] TICK_Y        = TICK_Y_DEF,
  parameter logic [9:0] TICK_X        = TICK_X_DEF
) (
  input  logic             clk,
  input  logic             reset,
  pong_game_ctrl_if.slave  bus
);

  localparam logic [7:0] WAIT_LOAD = 8'(WAIT_FRAMES);

  logic [1:0] r_state;
  logic       r_gra_still;
  logic [1:0] r_winner;
  logic [7:0] r_timer;
  logic       r_btn_d;
  logic       r_hit_d;

  logic [1:0] w_state_nxt;
  logic [1:0] w_winner_nxt;
  logic [7:0] w_timer_nxt;
  logic       w_clr_match;
  logic       w_clr_rally;
  logic       w_inc_l;
  logic       w_inc_r;
  logic       w_inc_rally;
  logic [7:0] w_score_l;
  logic [7:0] w_score_r;
  logic [7:0] w_rally;

  wire w_frame_tick = (bus.y == TICK_Y) && (bus.x == TICK_X);
  wire w_btn_rise   = (|bus.btn) & ~r_btn_d;
  wire w_hit_rise   = (|bus.hit) & ~r_hit_d;

  always_comb begin
    w_state_nxt  = r_state;
    w_winner_nxt = r_winner;
    w_timer_nxt  = r_timer;
    w_clr_match  = 1'b0;
    w_clr_rally  = 1'b0;
    w_inc_l      = 1'b0;
    w_inc_r      = 1'b0;
    w_inc_rally  = 1'b0;
    case (r_state)
      ST_NEWGAME: begin
        if (w_btn_rise) begin
          w_state_nxt  = ST_PLAY;
          w_clr_match  = 1'b1;
          w_winner_nxt = WIN_NONE;
        end
      end
      ST_PLAY: begin
        w_inc_rally = w_hit_rise;
        // leaving PLAY on the first miss cycle is what limits a miss to one point;
        // miss[0] has priority when both sides report together
        if (bus.miss[0]) begin
          w_inc_l     = 1'b1;
          w_timer_nxt = WAIT_LOAD;
          if (bcd2_inc(w_score_l) == WIN_SCORE_BCD) begin
            w_state_nxt  = ST_OVER;
            w_winner_nxt = WIN_LEFT;
          end else begin
            w_state_nxt = ST_NEWBALL;
          end
        end else if (bus.miss[1]) begin
          w_inc_r     = 1'b1;
          w_timer_nxt = WAIT_LOAD;
          if (bcd2_inc(w_score_r) == WIN_SCORE_BCD) begin
            w_state_nxt  = ST_OVER;
            w_winner_nxt = WIN_RIGHT;
          end else begin
            w_state_nxt = ST_NEWBALL;
          end
        end
      end
      ST_NEWBALL: begin
        if (r_timer == 8'd0) begin
          w_state_nxt = ST_PLAY;
          w_clr_rally = 1'b1;
        end else if (w_frame_tick) begin
          w_timer_nxt = r_timer - 8'd1;
        end
      end
      ST_OVER: begin
        if (r_timer == 8'd0) begin
          if (w_btn_rise)
            w_state_nxt = ST_NEWGAME;
        end else if (w_frame_tick) begin
          w_timer_nxt = r_timer - 8'd1;
        end
      end
      default: w_state_nxt = ST_NEWGAME;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_NEWGAME;
      r_gra_still <= 1'b1;
      r_winner    <= WIN_NONE;
      r_timer     <= 8'd0;
      r_btn_d     <= 1'b0;
      r_hit_d     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      // registered with the state so it is already valid in the first cycle of each state
      r_gra_still <= (w_state_nxt != ST_PLAY);
      r_winner    <= w_winner_nxt;
      r_timer     <= w_timer_nxt;
      r_btn_d     <= |bus.btn;
      r_hit_d     <= |bus.hit;
    end
  end

  bcd2_counter u_score_l (
    .clk(clk), .reset(reset), .i_clr(w_clr_match), .i_inc(w_inc_l), .o_count(w_score_l)
  );

  bcd2_counter u_score_r (
    .clk(clk), .reset(reset), .i_clr(w_clr_match), .i_inc(w_inc_r), .o_count(w_score_r)
  );

  bcd2_counter u_rally (
    .clk(clk), .reset(reset), .i_clr(w_clr_match | w_clr_rally), .i_inc(w_inc_rally),
    .o_count(w_rally)
  );

  assign bus.gra_still  = r_gra_still;
  assign bus.game_state = r_state;
  assign bus.score_l    = w_score_l;
  assign bus.score_r    = w_score_r;
  assign bus.rally      = w_rally;
  assign bus.winner     = r_winner;

endmodule
